// File: rtl/mips_lsu_pkg.sv
// Shared types and constants for the MIPS load/store unit.
// Alignment rules used when MIPS_LSU_ALIGN_CHECK_EN is defined.
package mips_lsu_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } lsu_state_e;

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] addr_lo
    );
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = (addr_lo != 2'b00);
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mips_load_extend.sv
// Narrows right-justified memory read data and sign/zero-extends it.
module mips_load_extend
    import mips_lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    logic sb;
    logic sh;

    assign sb = ~unsigned_i & data_i[7];
    assign sh = ~unsigned_i & data_i[15];

    always_comb begin
        data_o = data_i;
        case (size_i)
            SIZE_BYTE: data_o = {{24{sb}}, data_i[7:0]};
            SIZE_HALF: data_o = {{16{sh}}, data_i[15:0]};
            default:   data_o = data_i;
        endcase
    end

endmodule

// File: rtl/mips_load_store_unit.sv
// Data-memory initiator: one load/store at a time, fixed access time.
// Define MIPS_LSU_ALIGN_CHECK_EN to reject misaligned half/word requests.
module mips_load_store_unit
    import mips_lsu_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] address,
    output logic [31:0] write_data,
    output logic [1:0]  signal_store_control,
    output logic        signal_mem_read,
    output logic        signal_mem_write,
    input  logic [31:0] read_data
);

    localparam logic [CNT_W-1:0] CNT_INIT =
        CNT_W'(MEM_LATENCY - 1);

    lsu_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              write_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [31:0]       address_q;
    logic [31:0]       wdata_q;
    logic [1:0]        sc_q;
    logic              rd_q;
    logic              wr_q;
    logic              rvalid_q;
    logic [31:0]       rdata_q;
    logic              rerr_q;

    logic              illegal_d;
    logic [31:0]       ext_d;

`ifdef MIPS_LSU_ALIGN_CHECK_EN
    assign illegal_d = (req_size == SIZE_RSVD) ||
                       misaligned(req_size, req_addr[1:0]);
`else
    assign illegal_d = (req_size == SIZE_RSVD);
`endif

    mips_load_extend u_ext (
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_i     (read_data),
        .data_o     (ext_d)
    );

    // Strobes and response flags are registers, so the async
    // reset drops them immediately mid-transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            write_q   <= 1'b0;
            size_q    <= SIZE_WORD;
            uns_q     <= 1'b0;
            address_q <= '0;
            wdata_q   <= '0;
            sc_q      <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rerr_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        if (illegal_d) begin
                            state_q  <= ST_RESP;
                            rvalid_q <= 1'b1;
                            rerr_q   <= 1'b1;
                            rdata_q  <= '0;
                        end else begin
                            state_q   <= ST_ACCESS;
                            cnt_q     <= CNT_INIT;
                            address_q <= req_addr;
                            wdata_q   <= req_wdata;
                            sc_q      <= req_size;
                            rd_q      <= ~req_write;
                            wr_q      <= req_write;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q == '0) begin
                        rd_q     <= 1'b0;
                        wr_q     <= 1'b0;
                        rvalid_q <= 1'b1;
                        rerr_q   <= 1'b0;
                        rdata_q  <= write_q ? '0 : ext_d;
                        state_q  <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_q  <= ST_IDLE;
                        rvalid_q <= 1'b0;
                        rdata_q  <= '0;
                        rerr_q   <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready            = (state_q == ST_IDLE);
    assign resp_valid           = rvalid_q;
    assign resp_rdata           = rdata_q;
    assign resp_error           = rerr_q;
    assign address              = address_q;
    assign write_data           = wdata_q;
    assign signal_store_control = sc_q;
    assign signal_mem_read      = rd_q;
    assign signal_mem_write     = wr_q;

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Directed bench for mips_load_store_unit with MEM_LATENCY = 3.
module tb_mips_load_store_unit;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [1:0]  sc;
    logic        sig_rd;
    logic        sig_wr;
    logic [31:0] read_data;

    logic [31:0] mem_q = '0;
    logic [31:0] rd_force = '0;
    logic        use_mem = 1'b0;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    int          lat;
    int          nrd;
    int          nwr;
    int          nrdy;
    logic [31:0] a_seen;
    logic [1:0]  sc_seen;

    always #5 clk = ~clk;

    assign read_data = use_mem ? mem_q : rd_force;

    always @(posedge clk) if (sig_wr) mem_q <= write_data;

    mips_load_store_unit #(.MEM_LATENCY(LAT)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_write            (req_write),
        .req_size             (req_size),
        .req_unsigned         (req_unsigned),
        .req_addr             (req_addr),
        .req_wdata            (req_wdata),
        .resp_valid           (resp_valid),
        .resp_ready           (resp_ready),
        .resp_rdata           (resp_rdata),
        .resp_error           (resp_error),
        .address              (address),
        .write_data           (write_data),
        .signal_store_control (sc),
        .signal_mem_read      (sig_rd),
        .signal_mem_write     (sig_wr),
        .read_data            (read_data)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h",
                   tag, obs, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [1:0] sz,
                         input logic u, input logic [31:0] a,
                         input logic [31:0] wd);
        int k;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("ready_before_req", 32'(req_ready), 32'd1);
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic observe();
        lat = -1; nrd = 0; nwr = 0; nrdy = 0;
        a_seen = '0; sc_seen = '0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = i;
                break;
            end
            nrd += int'(sig_rd);
            nwr += int'(sig_wr);
            if (req_ready) nrdy++;
            if (sig_rd | sig_wr) begin
                a_seen  = address;
                sc_seen = sc;
            end
        end
    endtask

    task automatic txn(input string tag,
                       input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] a,
                       input logic [31:0] wd,
                       input int e_lat, input int e_rd,
                       input int e_wr, input logic e_err,
                       input logic [31:0] e_rdata);
        issue(w, sz, u, a, wd);
        observe();
        chk({tag, "_lat"}, 32'(lat), 32'(e_lat));
        chk({tag, "_nrd"}, 32'(nrd), 32'(e_rd));
        chk({tag, "_nwr"}, 32'(nwr), 32'(e_wr));
        chk({tag, "_rdy_busy"}, 32'(nrdy), 32'd0);
        chk({tag, "_err"}, 32'(resp_error), 32'(e_err));
        chk({tag, "_rdata"}, resp_rdata, e_rdata);
        if (e_rd + e_wr > 0) begin
            chk({tag, "_addr"}, a_seen, a);
            chk({tag, "_sc"}, 32'(sc_seen), 32'(sz));
        end
        @(negedge clk);
        chk({tag, "_hs_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_hs_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_hs_rdata"}, resp_rdata, 32'd0);
    endtask

    initial begin
        int cnt;

        // reset values
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_rd", 32'(sig_rd), 32'd0);
        chk("rst_wr", 32'(sig_wr), 32'd0);
        chk("rst_addr", address, 32'd0);
        chk("rst_wdata", write_data, 32'd0);
        chk("rst_sc", 32'(sc), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_error), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // word store then load through the bench memory
        use_mem = 1'b1;
        txn("st_w", 1'b1, 2'b00, 1'b0, 32'h0, 32'hFFFFFFFF,
            LAT + 1, 0, LAT, 1'b0, 32'h0);
        chk("st_w_mem", mem_q, 32'hFFFFFFFF);
        txn("ld_w", 1'b0, 2'b00, 1'b0, 32'h0, 32'h0,
            LAT + 1, LAT, 0, 1'b0, 32'hFFFFFFFF);

        // extension cases
        use_mem = 1'b0;
        rd_force = 32'h000000F0;
        txn("ld_bs", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,
            LAT + 1, LAT, 0, 1'b0, 32'hFFFFFFF0);
        txn("ld_bu", 1'b0, 2'b10, 1'b1, 32'h11, 32'h0,
            LAT + 1, LAT, 0, 1'b0, 32'h000000F0);
        rd_force = 32'h00008001;
        txn("ld_hs", 1'b0, 2'b01, 1'b0, 32'h20, 32'h0,
            LAT + 1, LAT, 0, 1'b0, 32'hFFFF8001);
        txn("ld_hu", 1'b0, 2'b01, 1'b1, 32'h22, 32'h0,
            LAT + 1, LAT, 0, 1'b0, 32'h00008001);
        rd_force = 32'h80000000;
        txn("ld_wu", 1'b0, 2'b00, 1'b1, 32'h24, 32'h0,
            LAT + 1, LAT, 0, 1'b0, 32'h80000000);

        // reserved size
        txn("err_ld", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0,
            1, 0, 0, 1'b1, 32'h0);
        txn("err_st", 1'b1, 2'b11, 1'b0, 32'h4, 32'h5,
            1, 0, 0, 1'b1, 32'h0);

        // misaligned half load
        rd_force = 32'h00008001;
`ifdef MIPS_LSU_ALIGN_CHECK_EN
        txn("mis_h", 1'b0, 2'b01, 1'b0, 32'h1, 32'h0,
            1, 0, 0, 1'b1, 32'h0);
        txn("mis_w", 1'b0, 2'b00, 1'b0, 32'h2, 32'h0,
            1, 0, 0, 1'b1, 32'h0);
`else
        txn("mis_h", 1'b0, 2'b01, 1'b0, 32'h1, 32'h0,
            LAT + 1, LAT, 0, 1'b0, 32'hFFFF8001);
`endif

        // response backpressure
        resp_ready = 1'b0;
        rd_force = 32'h000000A5;
        issue(1'b0, 2'b10, 1'b1, 32'h30, 32'h0);
        observe();
        chk("bp_lat", 32'(lat), 32'(LAT + 1));
        rd_force = 32'h0;
        req_write = 1'b1;
        req_size = 2'b00;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_rdata", resp_rdata, 32'h000000A5);
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_nowr", 32'(sig_wr), 32'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_ready", 32'(req_ready), 32'd1);
        chk("bp_hs_valid", 32'(resp_valid), 32'd0);

        // reset during ACCESS
        issue(1'b0, 2'b00, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        chk("mid_rd_on", 32'(sig_rd), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rd_off", 32'(sig_rd), 32'd0);
        chk("mid_valid", 32'(resp_valid), 32'd0);
        chk("mid_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid | sig_rd | sig_wr) cnt++;
        end
        chk("mid_no_resp", 32'(cnt), 32'd0);
        rd_force = 32'h12345678;
        txn("post_rst", 1'b0, 2'b00, 1'b0, 32'h44, 32'h0,
            LAT + 1, LAT, 0, 1'b0, 32'h12345678);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mips_load_store_unit.md
# mips_load_store_unit

Initiator side of the data-memory port: turns one load/store request from the datapath into the strobe sequence `mips_memory` expects, holds the strobes for a fixed access time, and returns load data narrowed and extended to 32 bits. Sits between the MEM stage and `mips_memory`, and drives every memory input that a bench would otherwise drive by hand. Handles one transaction at a time with a valid/ready request and response handshake.

## Interface
- `MEM_LATENCY`, default 1: cycles the memory strobes are held per access; legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request; equals state==IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 word, 01 halfword, 10 byte, 11 reserved.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts the response.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_error` out 1: request rejected without a memory access.
- `address` out 32: to memory.
- `write_data` out 32: to memory.
- `signal_store_control` out 2: to memory; same encoding as `req_size`.
- `signal_mem_read` out 1: to memory.
- `signal_mem_write` out 1: to memory.
- `read_data` in 32: from memory; the addressed item, right-justified.

## Operation
- States are IDLE, ACCESS and RESP. Reset state is IDLE.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, latch all request fields.
  - If the request is illegal, go to RESP with `resp_error`=1.
  - Otherwise go to ACCESS with the cycle counter loaded with `MEM_LATENCY`-1.
- **ACCESS**
  - Memory outputs are registered from the latched request: `address`, `write_data`, `signal_store_control`.
  - Exactly one of `signal_mem_read` / `signal_mem_write` is high.
  - The counter decrements each cycle. When it reaches 0:
    - For a load, capture the extended `read_data` into `resp_rdata`.
    - Clear both strobes.
    - Go to RESP.
- **RESP**
  - `resp_valid`=1. `resp_rdata` and `resp_error` are held stable.
  - On `resp_ready`, go to IDLE and clear `resp_valid`, `resp_rdata` and `resp_error`.
- **Extension rules**
  - Byte load: bits [7:0], extended from bit 7.
  - Half load: bits [15:0], extended from bit 15.
  - Word load: passed unchanged; `req_unsigned` is ignored.
- **Illegal requests**
  - `req_size`=11 is always illegal.
  - Misalignment is illegal only when the check is configured in (see Configuration).
  - An illegal request never asserts either memory strobe.
- Stores are not narrowed by this unit; `mips_memory` applies `signal_store_control` to `write_data`.
- A request arriving while not in IDLE is not accepted; `req_ready`=0 is the only backpressure.

## Timing
- Reset values:
  - `req_ready` = 1.
  - Every other output = 0, including all memory outputs and both strobes.
- Request accepted at edge T:
  - Strobes are high during cycles T+1 through T+`MEM_LATENCY`.
  - `resp_valid` rises at T+`MEM_LATENCY`+1.
- Error requests: `resp_valid` rises at T+1; no strobes are asserted.
- After the edge where `resp_valid` and `resp_ready` are both high, `req_ready` is 1 in the next cycle.
- Best-case throughput is one transaction per `MEM_LATENCY`+2 cycles.
- A store re-writes the same data on every edge of its strobe window; this is acceptable because repeated writes of the same data are idempotent.
- Reset asserted mid-operation:
  - Strobes and `resp_valid` clear immediately, without waiting for a clock edge.
  - The in-flight transaction is dropped and no response is produced.
  - After reset is released the unit is in IDLE.
- If `resp_ready` is held high, RESP still lasts at least one cycle.

## Configuration
- Macro: `MIPS_LSU_ALIGN_CHECK_EN`.
- Defined:
  - A halfword with `req_addr[0]`=1 is illegal (error response).
  - A word with `req_addr[1:0]`≠0 is illegal (error response).
- Undefined:
  - No alignment check.
  - The address is passed to memory unchanged.
  - Only `req_size`=11 produces an error.

## Structure
- Shared package `mips_lsu_pkg`:
  - Size constants: `SIZE_WORD`=2'b00, `SIZE_HALF`=2'b01, `SIZE_BYTE`=2'b10.
  - State enum.
  - Latency counter width constant (4 bits).
- Sub-module `mips_load_extend` (combinational):
  - Inputs: size, unsigned flag, raw 32-bit data.
  - Output: extended 32-bit result.
  - The top level instantiates it on `read_data`.

## Test plan
- **Word store then load.** Store word 0xFFFFFFFF to address 0, then load word from address 0 -> one write strobe cycle with `signal_store_control`=00; response `resp_rdata`=0xFFFFFFFF, `resp_error`=0.
- **Signed and unsigned byte load.** Memory returns 0x000000F0 -> signed byte load gives 0xFFFFFFF0; unsigned byte load gives 0x000000F0. Memory returns 0x00008001 -> signed half load gives 0xFFFF8001.
- **Latency and strobe width.** With `MEM_LATENCY`=3, a load accepted at T -> `signal_mem_read` is high exactly for cycles T+1..T+3; `resp_valid` rises at T+4; `req_ready`=0 throughout.
- **Error requests.** `req_size`=11 -> `resp_error`=1 at T+1, no strobes. With `MIPS_LSU_ALIGN_CHECK_EN`, a half load at address 0x1 -> error, no strobes; without the macro, the same request performs the access at address 0x1.
- **Response backpressure.** Hold `resp_ready` low for 3 cycles -> `resp_valid` and `resp_rdata` stay stable, `req_valid` is ignored; after the handshake, `req_ready`=1 in the next cycle.
- **Reset mid-access.** Assert `rst` during ACCESS -> strobes go to 0 immediately with no response; the next request after reset completes normally.
